// File: rtl/name_table_row_loader_pkg.sv
// ---------------------------------------------------------------------------
// name_table_row_loader_pkg
// Shared PPU define package for the background renderer and the name-table
// row loader: screen geometry of the name/attribute RAM and the loader FSM
// state encoding.
// ---------------------------------------------------------------------------
package name_table_row_loader_pkg;

    // Name/attribute RAM geometry (32-bit words).
    localparam logic [8:0] SCREEN_B_BASE   = 9'd256;  // first word of screen B
    localparam logic [8:0] ATTR_OFFSET     = 9'd240;  // attribute area within a screen
    localparam logic [5:0] ROWS_PER_SCREEN = 6'd30;   // logical rows per screen
    localparam logic [3:0] WORDS_PER_ROW   = 4'd8;    // name words per row
    localparam logic [3:0] ATTR_WORDS      = 4'd2;    // attribute words per 4-row group
    localparam logic [5:0] MAX_LOAD_ROW    = 6'd59;   // highest legal logical row

    // Row loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ldr_state_t;

    // Row within its screen for a logical row 0..59.
    function automatic logic [4:0] local_row(input logic [5:0] row);
        return 5'((row >= ROWS_PER_SCREEN) ? row - ROWS_PER_SCREEN : row);
    endfunction

endpackage

// File: rtl/name_table_row_loader.sv
// ---------------------------------------------------------------------------
// name_table_row_loader
// Copies one name-table row (8 words, plus 2 attribute words on every fourth
// row of a screen) from the map ROM into the name/attribute RAM.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   loadReq    : single-cycle load request (accepted only when idle)
//   loadRow    : logical row 0..59 (0..29 screen A, 30..59 screen B)
//   mapRow     : source row in the map ROM
//   mapAddr    : map ROM word address {row, word}
//   mapDataI   : map ROM data, valid the cycle after mapAddr
//   ntWrEn     : RAM write strobe
//   ntWrAddr   : RAM word address
//   ntWrData   : RAM write data (ROM data passed through)
//   busy       : load in progress
//   done       : one-cycle completion pulse
//   rowErr     : sticky, a request with loadRow > 59 was rejected
//   reqDropped : sticky, a request arrived while not idle
// ---------------------------------------------------------------------------
module name_table_row_loader
    import name_table_row_loader_pkg::*;
#(
    parameter int MAP_ROW_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      loadReq,
    input  logic [5:0]                loadRow,
    input  logic [MAP_ROW_BITS-1:0]   mapRow,
    output logic [MAP_ROW_BITS+3:0]   mapAddr,
    input  logic [31:0]               mapDataI,
    output logic                      ntWrEn,
    output logic [8:0]                ntWrAddr,
    output logic [31:0]               ntWrData,
    output logic                      busy,
    output logic                      done,
    output logic                      rowErr,
    output logic                      reqDropped
);

    ldr_state_t              r_state;
    logic [MAP_ROW_BITS-1:0] r_map_row;
    logic                    r_screen_b;
    logic [4:0]              r_local;
    logic                    r_attr;      // this row also carries attribute words
    logic [3:0]              r_k;         // word index currently on mapAddr
    logic [31:0]             r_data_hold; // last written word, shown while idle

    logic       w_req_bad;
    logic       w_req_screen_b;
    logic [4:0] w_req_local;
    logic [8:0] w_base;
    logic [8:0] w_name_addr;
    logic [8:0] w_attr_addr;
    logic [8:0] w_wr_addr;
    logic [3:0] w_last_k;

    assign w_req_bad      = (loadRow > MAX_LOAD_ROW);
    assign w_req_screen_b = (loadRow >= ROWS_PER_SCREEN);
    assign w_req_local    = local_row(loadRow);

    // RAM address for the word whose ROM address is on mapAddr this cycle.
    // Name words: base + local*8 + k. Attribute words (k = 8, 9): one pair per
    // group of four rows, so base + 240 + (local>>2)*2 + k[0].
    assign w_base      = r_screen_b ? SCREEN_B_BASE : 9'd0;
    assign w_name_addr = w_base + {1'b0, r_local, 3'b000} + {5'd0, r_k};
    assign w_attr_addr = w_base + ATTR_OFFSET + {5'd0, r_local[4:2], 1'b0} + {8'd0, r_k[0]};
    assign w_wr_addr   = (r_k < WORDS_PER_ROW) ? w_name_addr : w_attr_addr;
    assign w_last_k    = r_attr ? (WORDS_PER_ROW + ATTR_WORDS - 4'd1)
                                : (WORDS_PER_ROW - 4'd1);

    // The ROM answers in the write cycle itself, so the data goes straight
    // through while writing; otherwise the last written word is held.
    assign ntWrData = ntWrEn ? mapDataI : r_data_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= 4'd0;
            r_data_hold <= 32'd0;
            mapAddr     <= '0;
            ntWrEn      <= 1'b0;
            ntWrAddr    <= 9'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rowErr      <= 1'b0;
            reqDropped  <= 1'b0;
        end else begin
            if (ntWrEn) begin
                r_data_hold <= mapDataI;
            end
            // Any request outside IDLE (including the done cycle) is dropped.
            if (loadReq && (r_state != ST_IDLE)) begin
                reqDropped <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (loadReq) begin
                        if (w_req_bad) begin
                            // Rejected: no ROM/RAM traffic, just the done pulse.
                            rowErr  <= 1'b1;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            rowErr     <= 1'b0;
                            reqDropped <= 1'b0;
                            r_map_row  <= mapRow;
                            r_screen_b <= w_req_screen_b;
                            r_local    <= w_req_local;
                            r_attr     <= (w_req_local[1:0] == 2'b00);
                            r_k        <= 4'd0;
                            mapAddr    <= {mapRow, 4'd0};
                            busy       <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Schedule the write for word k one cycle behind its read.
                    ntWrEn   <= 1'b1;
                    ntWrAddr <= w_wr_addr;
                    if (r_k == w_last_k) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k     <= r_k + 4'd1;
                        mapAddr <= {r_map_row, r_k + 4'd1};
                    end
                end
                ST_DRAIN: begin
                    ntWrEn  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/name_table_row_loader.md
NAME_TABLE_ROW_LOADER -- requirements
Module: name_table_row_loader

Interface
REQ-001 SHALL have parameter MAP_ROW_BITS, default 10, the width of the map ROM row index.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port loadReq, input, 1: single-cycle row-load request.
REQ-005 SHALL have port loadRow, input, 6: the logical name-table row to fill, 0..59; rows 0..29 are screen A and rows 30..59 are screen B.
REQ-006 SHALL have port mapRow, input, MAP_ROW_BITS: the source row in the map ROM.
REQ-007 SHALL have port mapAddr, output, MAP_ROW_BITS+4: the map ROM word address.
REQ-008 SHALL have port mapDataI, input, 32: map ROM read data, valid one cycle after mapAddr.
REQ-009 SHALL have port ntWrEn, output, 1: name/attribute RAM write strobe.
REQ-010 SHALL have port ntWrAddr, output, 9: the RAM word address.
REQ-011 SHALL have port ntWrData, output, 32: the RAM write word.
REQ-012 SHALL have port busy, output, 1: high while a load is in progress.
REQ-013 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-014 SHALL have port rowErr, output, 1: sticky flag for a rejected request (loadRow > 59).
REQ-015 SHALL have port reqDropped, output, 1: sticky flag for a request that arrived while busy.

Function
REQ-016 SHALL accept loadReq only in IDLE; on acceptance, latch loadRow and mapRow and raise busy on the next cycle.
REQ-017 SHALL, when loadReq arrives while busy, ignore it, set reqDropped, and leave the current load unaffected.
REQ-018 SHALL clear rowErr and reqDropped on the next accepted valid request.
REQ-019 SHALL, on a request with loadRow > 59, perform no ROM reads or RAM writes, set rowErr, and pulse done one cycle later.
REQ-020 SHALL compute the screen base and local row as follows: loadRow 0..29 gives base 0 and local row loadRow; loadRow 30..59 gives base 256 and local row loadRow-30.
REQ-021 SHALL write the name words for word index k = 0..7 to ntWrAddr = base + local*8 + k, from mapAddr = {mapRow, k[3:0]}.
REQ-022 SHALL, when local[1:0] == 0, additionally copy map words 8 and 9 to ntWrAddr = base + 240 + (local>>2)*2 + (k-8), giving 10 words in total; otherwise copy 8 words.
REQ-023 SHALL use a states IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-024 SHALL, in ISSUE, present one mapAddr per cycle with k incrementing.
REQ-025 SHALL, in DRAIN, perform the final write.
REQ-026 SHALL, in DONE, pulse done and drop busy.
REQ-027 SHALL pipeline ROM read and RAM write exactly one cycle apart: mapAddr for k in cycle c, and ntWrEn with the ROM data for k in cycle c+1.
REQ-028 SHALL pass ntWrData equal to mapDataI unmodified.
REQ-029 SHALL meet this timing for a request accepted at cycle 0:
- first mapAddr at cycle 1;
- first ntWrEn at cycle 2;
- last write at cycle 9 (8 words) or cycle 11 (10 words);
- done at cycle 10 or 12.
REQ-030 SHALL keep ntWrEn low outside write cycles and never assert it twice for the same address within one load.
REQ-031 SHALL permit a loadReq in the cycle done is high, treating it as dropped; a request in the following cycle SHALL be accepted.
REQ-032 SHALL hold mapAddr, ntWrAddr and ntWrData at their last values when idle.

Reset
REQ-033 SHALL, on rst, return the FSM to IDLE and set busy, done, ntWrEn, rowErr, reqDropped, mapAddr, ntWrAddr and ntWrData to 0.
REQ-034 SHALL, when rst is asserted mid-load, abort the load with no further writes and no done pulse; partially written words remain in RAM.

Structure
REQ-035 SHALL place the screen-B base (256), the attribute offset (240), the rows per screen (30) and the words per row (8) in the shared PPU define package used by the background renderer.
REQ-036 SHALL place the FSM state encoding in the same shared define package.
REQ-037 SHALL be a single module with no sub-modules; the address computation is inline combinational logic off latched registers.

Verification
REQ-038 SHALL verify this scenario: loadReq with loadRow=5, mapRow=3 -> 8 writes to addresses 40..47 with data from ROM words 48..55, done at cycle 10, no attribute write.
REQ-039 SHALL verify this scenario: loadRow=32 (local 2), mapRow=0 -> writes to 272..279, done at cycle 10.
REQ-040 SHALL verify this scenario: loadRow=34 (local 4), mapRow=7 -> writes to 288..295, then attribute writes to 498 and 499 from ROM words 120 and 121, done at cycle 12.
REQ-041 SHALL verify this scenario: loadRow=60 -> no writes, rowErr=1, done at cycle 1; a subsequent valid request clears rowErr.
REQ-042 SHALL verify this scenario: second loadReq at cycle 4 of a load -> reqDropped=1, with the first load's write sequence unchanged.
REQ-043 SHALL verify this scenario: rst asserted at cycle 5 of a load -> the cycle after, busy=0 and ntWrEn=0, no done pulse, and a new request completes normally.
